// File: rtl/alu_seq_pkg.sv
// Opcodes, sequencer state encoding and the per-opcode ALU stage count.
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 6;
    localparam int CTL_W  = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b100001;
    localparam logic [OP_W-1:0] OP_MUL   = 6'b100010;
    localparam logic [OP_W-1:0] OP_DIV   = 6'b100011;
    localparam logic [OP_W-1:0] OP_INC   = 6'b100100;
    localparam logic [OP_W-1:0] OP_MOD   = 6'b100101;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010010;
    localparam logic [OP_W-1:0] OP_OR    = 6'b010011;
    localparam logic [OP_W-1:0] OP_XOR   = 6'b010100;
    localparam logic [OP_W-1:0] OP_NOT   = 6'b010101;
    localparam logic [OP_W-1:0] OP_CMP   = 6'b010110;
    localparam logic [OP_W-1:0] OP_SHIFT = 6'b010000;
    localparam logic [OP_W-1:0] OP_FRLD  = 6'b000110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_GAP
    } seq_state_t;

    // Number of enable posedges the ALU needs for an opcode; 0 marks an illegal opcode.
    function automatic logic [2:0] alu_lat(input logic [OP_W-1:0] op);
        case (op)
            OP_INC, OP_CMP, OP_SHIFT, OP_FRLD:                          return 3'd2;
            OP_ADD, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_NOT: return 3'd3;
            OP_SUB:                                                     return 3'd4;
            default:                                                    return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_rr_arb.sv
// Two-requester arbiter. Round-robin by default; defining ALU_SEQ_FIXED_PRIO_EN
// makes port 0 always win contention.
module alu_seq_rr_arb (
    input  logic       wire_clock,
    input  logic       wire_reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef ALU_SEQ_FIXED_PRIO_EN
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            last_grant <= 1'b0;
        end else if (advance && (req != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Two-port front end for the multi-stage ALU: arbitrates requests, pulses
// alu_enable for the opcode's stage count, captures result/flags and responds.
//
// state      | meaning
// ST_IDLE    | waiting; grant a request and latch its operands
// ST_ISSUE   | alu_enable high, counting down the opcode's stage count
// ST_CAPTURE | enable low; sample alu_m2/alu_fr_out and pulse the response
// ST_GAP     | extra enable-low cycles so the ALU sees a fresh rising edge
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic              wire_clock,
    input  logic              wire_reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTL_W-1:0]  req0_ctl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTL_W-1:0]  req1_ctl,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [DATA_W-1:0] fr_q,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_m3,
    output logic [DATA_W-1:0] alu_m4,
    output logic              alu_use_carry,
    output logic [2:0]        alu_shift_flag,
    output logic              alu_dec,
    output logic [DATA_W-1:0] alu_fr_in,
    input  logic [DATA_W-1:0] alu_m2,
    input  logic [DATA_W-1:0] alu_fr_out
);

    seq_state_t        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        gnt;
    logic              take;
    logic              owner_q;
    logic [CTL_W-1:0]  ctl_q;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [CTL_W-1:0]  sel_ctl;
    logic [2:0]        sel_lat;

    alu_seq_rr_arb u_arb (
        .wire_clock   (wire_clock),
        .wire_reset_n (wire_reset_n),
        .req          ({req1_valid, req0_valid}),
        .advance      (state_q == ST_IDLE),
        .gnt          (gnt)
    );

    assign take       = (state_q == ST_IDLE) && (gnt != 2'b00);
    assign req0_ready = take & gnt[0];
    assign req1_ready = take & gnt[1];

    always_comb begin
        sel_op  = req0_op;
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_ctl = req0_ctl;
        if (gnt[1]) begin
            sel_op  = req1_op;
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_ctl = req1_ctl;
        end
    end

    assign sel_lat = alu_lat(sel_op);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Illegal opcodes stay in IDLE; their error response is raised directly.
                if (take && (sel_lat != 3'd0)) begin
                    state_d = ST_ISSUE;
                    cnt_d   = {5'd0, sel_lat - 3'd1};
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CAPTURE: begin
                if (GAP_CYCLES > 1) begin
                    state_d = ST_GAP;
                    cnt_d   = 8'(GAP_CYCLES - 2);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            alu_op     <= '0;
            alu_m3     <= '0;
            alu_m4     <= '0;
            ctl_q      <= '0;
            owner_q    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_result <= '0;
            fr_q       <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (take) begin
                alu_op  <= sel_op;
                alu_m3  <= sel_a;
                alu_m4  <= sel_b;
                ctl_q   <= sel_ctl;
                owner_q <= gnt[1];
                if (sel_lat == 3'd0) begin
                    rsp0_valid <= gnt[0];
                    rsp1_valid <= gnt[1];
                    rsp_err    <= 1'b1;
                    rsp_result <= '0;
                end
            end
            if (state_q == ST_CAPTURE) begin
                rsp_result <= alu_m2;
                fr_q       <= alu_fr_out;
                rsp_err    <= 1'b0;
                rsp0_valid <= ~owner_q;
                rsp1_valid <= owner_q;
            end
        end
    end

    assign alu_enable     = (state_q == ST_ISSUE);
    assign alu_use_carry  = ctl_q[4];
    assign alu_shift_flag = ctl_q[3:1];
    assign alu_dec        = ctl_q[0];
    assign alu_fr_in      = fr_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural multi-stage ALU
// and a transaction-level reference model of arbitration, latency and flags.
module tb_alu_op_sequencer;

    localparam int GAP = 1;

    localparam logic [5:0] T_ADD = 6'b100000, T_SUB = 6'b100001, T_MUL = 6'b100010;
    localparam logic [5:0] T_DIV = 6'b100011, T_INC = 6'b100100, T_MOD = 6'b100101;
    localparam logic [5:0] T_AND = 6'b010010, T_OR  = 6'b010011, T_XOR = 6'b010100;
    localparam logic [5:0] T_NOT = 6'b010101, T_CMP = 6'b010110, T_SHIFT = 6'b010000;
    localparam logic [5:0] T_FRLD = 6'b000110, T_BAD = 6'b111111;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] f;
        logic        w;
    } alu_out_t;

    logic        wire_clock = 1'b0;
    logic        wire_reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [5:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_ctl, req1_ctl;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic [15:0] fr_q;
    logic        alu_enable;
    logic [5:0]  alu_op;
    logic [15:0] alu_m3, alu_m4;
    logic        alu_use_carry;
    logic [2:0]  alu_shift_flag;
    logic        alu_dec;
    logic [15:0] alu_fr_in;
    logic [15:0] alu_m2, alu_fr_out;

    int          checks = 0;
    int          failures = 0;
    int          lat_tab [64];
    logic [15:0] model_fr = 16'h0;
    int          model_last = 0;
    logic [5:0]  op_list [14] = '{T_ADD, T_SUB, T_MUL, T_DIV, T_INC, T_MOD, T_AND,
                                  T_OR, T_XOR, T_NOT, T_CMP, T_SHIFT, T_FRLD, T_BAD};

    always #5 wire_clock = ~wire_clock;

    alu_op_sequencer #(.GAP_CYCLES(GAP)) dut (
        .wire_clock     (wire_clock),
        .wire_reset_n   (wire_reset_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_op        (req0_op),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_ctl       (req0_ctl),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_op        (req1_op),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_ctl       (req1_ctl),
        .rsp0_valid     (rsp0_valid),
        .rsp1_valid     (rsp1_valid),
        .rsp_result     (rsp_result),
        .rsp_err        (rsp_err),
        .fr_q           (fr_q),
        .alu_enable     (alu_enable),
        .alu_op         (alu_op),
        .alu_m3         (alu_m3),
        .alu_m4         (alu_m4),
        .alu_use_carry  (alu_use_carry),
        .alu_shift_flag (alu_shift_flag),
        .alu_dec        (alu_dec),
        .alu_fr_in      (alu_fr_in),
        .alu_m2         (alu_m2),
        .alu_fr_out     (alu_fr_out)
    );

    // ALU behaviour: flag bits 15:13 = {gt,lt,eq}, 12 zero, 11 carry, 9 div-by-zero, 6 borrow.
    function automatic alu_out_t alu_eval(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] ctl, input logic [15:0] fr);
        alu_out_t    o;
        logic [16:0] s;
        o.r = 16'h0;
        o.f = fr;
        o.w = 1'b1;
        case (op)
            T_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {16'h0, ctl[4] & fr[11]};
                o.r = s[15:0];
                o.f[11] = s[16];
            end
            T_SUB: begin o.r = a - b; o.f[6] = (a < b); end
            T_MUL: o.r = a * b;
            T_DIV: if (b == 16'h0) o.f[9] = 1'b1; else o.r = a / b;
            T_MOD: if (b == 16'h0) o.f[9] = 1'b1; else o.r = a % b;
            T_INC: o.r = ctl[0] ? a - 16'd1 : a + 16'd1;
            T_AND: o.r = a & b;
            T_OR:  o.r = a | b;
            T_XOR: o.r = a ^ b;
            T_NOT: o.r = ~a;
            T_SHIFT: o.r = (ctl[3:1] == 3'd0) ? a << 1 : a >> ctl[3:1];
            T_CMP: begin o.w = 1'b0; o.f[15:13] = {a > b, a < b, a == b}; end
            T_FRLD: begin o.r = a; o.f = a; end
            default: o.w = 1'b0;
        endcase
        if (o.w && op != T_FRLD) o.f[12] = (o.r == 16'h0);
        return o;
    endfunction

    // Environment ALU: result appears only after the opcode's full count of enable posedges.
    alu_out_t env_res;
    int       env_stage;
    always_comb env_res = alu_eval(alu_op, alu_m3, alu_m4, {alu_use_carry, alu_shift_flag, alu_dec}, alu_fr_in);

    always @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            env_stage <= 0;
        end else if (alu_enable) begin
            env_stage <= env_stage + 1;
            if (env_stage + 1 == lat_tab[alu_op]) begin
                if (env_res.w) alu_m2 <= env_res.r;
                alu_fr_out <= env_res.f;
            end
        end else begin
            env_stage <= 0;
        end
    end

    task automatic issue_op(input int port, input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [4:0] ctl, output int en_cnt, output int rsp_port, output int lat,
                            output logic [15:0] res, output logic err, output logic [15:0] fr, output bit to);
        int n;
        n = 0; en_cnt = 0; rsp_port = -1; lat = 0; res = '0; err = 1'b0; fr = '0; to = 1'b0;
        @(negedge wire_clock);
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_ctl = ctl;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_ctl = ctl;
        end
        #1;
        while (!(port == 0 ? req0_ready : req1_ready)) begin
            n++;
            if (n > 50) begin to = 1'b1; break; end
            @(negedge wire_clock); #1;
        end
        @(negedge wire_clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        while (!to && rsp_port < 0) begin
            lat++;
            if (alu_enable) en_cnt++;
            if (rsp0_valid || rsp1_valid) begin
                rsp_port = rsp1_valid ? 1 : 0;
                res = rsp_result; err = rsp_err; fr = fr_q;
            end else if (lat > 60) begin
                to = 1'b1;
            end else begin
                @(negedge wire_clock); #1;
            end
        end
    endtask

    task automatic test_reset();
        wire_reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0; req0_ctl = '0;
        req1_op = '0; req1_a = '0; req1_b = '0; req1_ctl = '0;
        repeat (3) @(negedge wire_clock);
        #1;
        checks++;
        if ({alu_enable, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready} !== 6'b0) begin
            failures++; $display("FAIL reset_ctl: got %b required 000000", {alu_enable, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready});
        end
        checks++;
        if ({fr_q, alu_fr_in, rsp_result} !== 48'h0) begin
            failures++; $display("FAIL reset_fr: fr_q=%h fr_in=%h result=%h required 0", fr_q, alu_fr_in, rsp_result);
        end
        checks++;
        if ({alu_op, alu_m3, alu_m4, alu_use_carry, alu_shift_flag, alu_dec} !== 43'h0) begin
            failures++; $display("FAIL reset_alu_regs: op=%h m3=%h m4=%h required 0", alu_op, alu_m3, alu_m4);
        end
        @(negedge wire_clock);
        wire_reset_n = 1'b1;
        @(negedge wire_clock); #1;
        checks++;
        if (alu_enable !== 1'b0) begin
            failures++; $display("FAIL post_reset_enable: got %b required 0", alu_enable);
        end
    endtask

    task automatic test_add();
        alu_out_t e; int en, rp, lt; logic [15:0] r, f; logic er; bit to;
        e = alu_eval(T_ADD, 16'hFFFF, 16'h0002, 5'd0, model_fr);
        issue_op(0, T_ADD, 16'hFFFF, 16'h0002, 5'd0, en, rp, lt, r, er, f, to);
        model_fr = e.f; model_last = 0;
        checks++; if (to) begin failures++; $display("FAIL add_timeout: no response within bound"); end
        checks++; if (en != 3) begin failures++; $display("FAIL add_enable_len: got %0d required 3", en); end
        checks++; if (rp != 0 || lt != 5) begin failures++; $display("FAIL add_rsp: port=%0d lat=%0d required port 0 lat 5", rp, lt); end
        checks++; if (r !== 16'h0001 || er !== 1'b0) begin failures++; $display("FAIL add_result: got %h err=%b required 0001 err=0", r, er); end
        checks++; if (f[11] !== 1'b1 || f[12] !== 1'b0 || f !== model_fr) begin failures++; $display("FAIL add_flags: got %h required %h", f, model_fr); end
        @(negedge wire_clock); #1;
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL add_rsp_pulse: rsp0_valid still %b, required 0", rsp0_valid); end
    endtask

    task automatic test_sub();
        alu_out_t e; int en, rp, lt; logic [15:0] r, f; logic er; bit to;
        e = alu_eval(T_SUB, 16'd5, 16'd5, 5'd0, model_fr);
        issue_op(1, T_SUB, 16'd5, 16'd5, 5'd0, en, rp, lt, r, er, f, to);
        model_fr = e.f; model_last = 1;
        checks++; if (to) begin failures++; $display("FAIL sub_timeout: no response within bound"); end
        checks++; if (en != 4) begin failures++; $display("FAIL sub_enable_len: got %0d required 4", en); end
        checks++; if (rp != 1 || lt != 6) begin failures++; $display("FAIL sub_rsp: port=%0d lat=%0d required port 1 lat 6", rp, lt); end
        checks++; if (r !== 16'h0000 || er !== 1'b0) begin failures++; $display("FAIL sub_result: got %h err=%b required 0000 err=0", r, er); end
        checks++; if (f[12] !== 1'b1 || f[6] !== 1'b0 || f !== model_fr) begin failures++; $display("FAIL sub_flags: got %h required %h", f, model_fr); end
    endtask

    task automatic test_back_to_back();
        int          exp_port_q[$];
        logic [15:0] exp_res_q[$];
        logic [15:0] exp_fr_q[$];
        int          pend = -1;
        int          last_g = -1;
        int          grants = 0;
        int          g, exp_g, p;
        logic [15:0] er, ef;
        alu_out_t    e;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge wire_clock);
            if (cyc == 0) begin
                req0_op = T_INC; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_ctl = 5'($urandom) & 5'b00001;
                req1_op = T_INC; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_ctl = 5'($urandom) & 5'b00001;
                req0_valid = 1'b1; req1_valid = 1'b1;
            end else if (cyc == 48) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end else if (pend == 0) begin
                req0_a = 16'($urandom); req0_ctl = 5'($urandom) & 5'b00001;
            end else if (pend == 1) begin
                req1_a = 16'($urandom); req1_ctl = 5'($urandom) & 5'b00001;
            end
            pend = -1;
            #1;
            if (rsp0_valid || rsp1_valid) begin
                checks++;
                if (exp_port_q.size() == 0) begin
                    failures++; $display("FAIL b2b_spurious_rsp: rsp0=%b rsp1=%b with nothing outstanding", rsp0_valid, rsp1_valid);
                end else begin
                    p = exp_port_q.pop_front(); er = exp_res_q.pop_front(); ef = exp_fr_q.pop_front();
                    if ({rsp1_valid, rsp0_valid} !== (p == 1 ? 2'b10 : 2'b01) || rsp_result !== er || fr_q !== ef) begin
                        failures++; $display("FAIL b2b_rsp: rsp=%b%b result=%h fr=%h required port %0d result=%h fr=%h", rsp1_valid, rsp0_valid, rsp_result, fr_q, p, er, ef);
                    end
                end
            end
            if (req0_ready && req1_ready) begin
                checks++; failures++; $display("FAIL b2b_dual_ready: both readies high at cycle %0d", cyc);
            end else if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
`ifdef ALU_SEQ_FIXED_PRIO_EN
                exp_g = 0;
`else
                exp_g = (model_last == 0) ? 1 : 0;
`endif
                checks++;
                if (g != exp_g) begin failures++; $display("FAIL b2b_winner: got port %0d required port %0d", g, exp_g); end
                if (last_g >= 0) begin
                    checks++;
                    if (cyc - last_g != 1 + 2 + GAP) begin failures++; $display("FAIL b2b_spacing: got %0d cycles required %0d", cyc - last_g, 1 + 2 + GAP); end
                end
                e = (g == 1) ? alu_eval(T_INC, req1_a, req1_b, req1_ctl, model_fr) : alu_eval(T_INC, req0_a, req0_b, req0_ctl, model_fr);
                model_fr = e.f;
                exp_port_q.push_back(g); exp_res_q.push_back(e.r); exp_fr_q.push_back(e.f);
                model_last = g; last_g = cyc; pend = g; grants++;
            end
            if (cyc >= 48 && exp_port_q.size() == 0) break;
        end
        checks++;
        if (exp_port_q.size() != 0 || grants < 10) begin
            failures++; $display("FAIL b2b_drain: outstanding=%0d grants=%0d required 0 outstanding and >=10 grants", exp_port_q.size(), grants);
        end
    endtask

    task automatic test_div_cmp();
        alu_out_t e; int en, rp, lt; logic [15:0] r, f; logic er; bit to;
        e = alu_eval(T_DIV, 16'd1234, 16'd0, 5'd0, model_fr);
        issue_op(0, T_DIV, 16'd1234, 16'd0, 5'd0, en, rp, lt, r, er, f, to);
        model_fr = e.f; model_last = 0;
        checks++; if (to || en != 3 || rp != 0) begin failures++; $display("FAIL div_seq: to=%0d en=%0d port=%0d required 0/3/0", to, en, rp); end
        checks++; if (f[9] !== 1'b1 || f !== model_fr) begin failures++; $display("FAIL div_flags: got %h required %h", f, model_fr); end
        e = alu_eval(T_CMP, 16'd3, 16'd7, 5'd0, model_fr);
        issue_op(1, T_CMP, 16'd3, 16'd7, 5'd0, en, rp, lt, r, er, f, to);
        model_fr = e.f; model_last = 1;
        checks++; if (to || en != 2 || rp != 1 || lt != 4) begin failures++; $display("FAIL cmp_seq: to=%0d en=%0d port=%0d lat=%0d required 0/2/1/4", to, en, rp, lt); end
        checks++; if (f[15:13] !== 3'b010 || f[9] !== 1'b1 || f !== model_fr) begin failures++; $display("FAIL cmp_flags: got %h required %h", f, model_fr); end
    endtask

    task automatic test_illegal();
        int en, rp, lt; logic [15:0] r, f; logic er; bit to;
        issue_op(0, T_BAD, 16'hABCD, 16'h1234, 5'd0, en, rp, lt, r, er, f, to);
        model_last = 0;
        checks++; if (to || en != 0) begin failures++; $display("FAIL illegal_enable: to=%0d enable cycles=%0d required 0", to, en); end
        checks++; if (rp != 0 || lt != 1) begin failures++; $display("FAIL illegal_rsp: port=%0d lat=%0d required port 0 lat 1", rp, lt); end
        checks++; if (er !== 1'b1 || r !== 16'h0) begin failures++; $display("FAIL illegal_err: err=%b result=%h required 1/0000", er, r); end
        checks++; if (f !== model_fr) begin failures++; $display("FAIL illegal_fr: got %h required %h", f, model_fr); end
    endtask

    task automatic test_reset_mid_op();
        int n = 0; int en, rp, lt; logic [15:0] r, f; logic er; bit to; bit saw_rsp = 1'b0;
        @(negedge wire_clock);
        req0_valid = 1'b1; req0_op = T_MUL; req0_a = 16'd7; req0_b = 16'd9; req0_ctl = 5'd0;
        #1;
        while (!req0_ready && n < 50) begin @(negedge wire_clock); #1; n++; end
        @(negedge wire_clock);
        req0_valid = 1'b0;
        @(posedge wire_clock); #1;
        checks++; if (alu_enable !== 1'b1 || n >= 50) begin failures++; $display("FAIL rstmid_pre_enable: got %b required 1", alu_enable); end
        wire_reset_n = 1'b0;
        #1;
        checks++; if (alu_enable !== 1'b0 || fr_q !== 16'h0) begin failures++; $display("FAIL rstmid_drop: enable=%b fr=%h required 0/0000", alu_enable, fr_q); end
        repeat (3) begin @(negedge wire_clock); #1; if (rsp0_valid || rsp1_valid) saw_rsp = 1'b1; end
        wire_reset_n = 1'b1;
        repeat (5) begin @(negedge wire_clock); #1; if (rsp0_valid || rsp1_valid || alu_enable) saw_rsp = 1'b1; end
        checks++; if (saw_rsp) begin failures++; $display("FAIL rstmid_lost_rsp: activity seen after reset, required none"); end
        model_fr = 16'h0; model_last = 0;
        issue_op(0, T_MUL, 16'd3, 16'd4, 5'd0, en, rp, lt, r, er, f, to);
        checks++; if (to || en != 3 || rp != 0 || r !== 16'd12) begin failures++; $display("FAIL rstmid_next_mul: to=%0d en=%0d port=%0d result=%h required 0/3/0/000c", to, en, rp, r); end
        model_fr = alu_eval(T_MUL, 16'd3, 16'd4, 5'd0, model_fr).f;
    endtask

    task automatic test_random();
        alu_out_t e; int en, rp, lt, port, lat; logic [15:0] r, f, a, b; logic er; bit to; logic [5:0] op; logic [4:0] ctl;
        for (int i = 0; i < 30; i++) begin
            op   = op_list[$urandom_range(0, 13)];
            port = $urandom_range(0, 1);
            a    = 16'($urandom);
            b    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            ctl  = 5'($urandom);
            lat  = lat_tab[op];
            e    = alu_eval(op, a, b, ctl, model_fr);
            issue_op(port, op, a, b, ctl, en, rp, lt, r, er, f, to);
            model_last = port;
            checks++;
            if (to || en != lat || rp != port || lt != ((lat == 0) ? 1 : lat + 2)) begin
                failures++; $display("FAIL rand_seq op=%b: to=%0d en=%0d port=%0d lat=%0d required en=%0d port=%0d", op, to, en, rp, lt, lat, port);
            end
            if (lat == 0) begin
                checks++;
                if (er !== 1'b1 || r !== 16'h0 || f !== model_fr) begin failures++; $display("FAIL rand_illegal: err=%b result=%h fr=%h required 1/0000/%h", er, r, f, model_fr); end
            end else begin
                model_fr = e.f;
                checks++;
                if (er !== 1'b0 || f !== model_fr || (e.w && r !== e.r)) begin
                    failures++; $display("FAIL rand_result op=%b: err=%b result=%h fr=%h required 0/%h/%h", op, er, r, f, e.r, model_fr);
                end
            end
        end
    endtask

    initial begin
        foreach (lat_tab[i]) lat_tab[i] = 0;
        lat_tab[T_INC] = 2; lat_tab[T_CMP] = 2; lat_tab[T_SHIFT] = 2; lat_tab[T_FRLD] = 2;
        lat_tab[T_ADD] = 3; lat_tab[T_MUL] = 3; lat_tab[T_DIV] = 3; lat_tab[T_MOD] = 3;
        lat_tab[T_AND] = 3; lat_tab[T_OR] = 3; lat_tab[T_XOR] = 3; lat_tab[T_NOT] = 3;
        lat_tab[T_SUB] = 4;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_div_cmp();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog expired");
    end

endmodule
